pb_bounce_gen: RTL

Synthesizable push-button bounce generator that drives a bouncy `PB` level, so the debouncer can be exercised in simulation and on-board without a mechanical switch. On a press or release request it emits a burst of pseudo-random-spaced toggles that ends on the target level, then holds that level for a settle interval. It sits upstream of `debouncer`, on the same `clk_20mhz` domain, with its `PB` output feeding the debouncer's `PB` input.

---
 rtl/pb_sim_pkg.sv | 19 +
 rtl/lfsr16.sv | 22 ++
 rtl/pb_bounce_gen.sv | 115 +++++++++++
 3 files changed

// File: rtl/pb_sim_pkg.sv
// Shared types and constants for the push-button bounce generator.
// Holds the FSM encoding, LFSR polynomial and the Galois step function.
package pb_sim_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BOUNCE,
      SETTLE,
      HELD
   } pb_gen_state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps only when adv is high.
// Supplies the pseudo-random gap lengths for the bounce burst.
module lfsr16
   import pb_sim_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic        clk_20mhz,
   input  logic        rst,
   input  logic        adv,
   output logic [15:0] q
);

   always_ff @(posedge clk_20mhz or posedge rst) begin
      if (rst) begin
         q <= SEED;
      end else if (adv) begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/pb_bounce_gen.sv
// Bouncy push-button source: random-spaced toggle burst ending on the
// requested level, then a settle hold before reporting done.
module pb_bounce_gen
   import pb_sim_pkg::*;
#(
   parameter int          N_TOGGLES     = 7,
   parameter int          GAP_BITS      = 8,
   parameter int          SETTLE_CYCLES = 1000,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic clk_20mhz,
   input  logic rst,
   input  logic press_req,
   input  logic release_req,
   output logic PB,
   output logic busy,
   output logic held,
   output logic done
);

   localparam int TW = $clog2(N_TOGGLES + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int GW = GAP_BITS + 1;

   localparam logic [TW-1:0] T_LAST = TW'(N_TOGGLES);
   localparam logic [SW-1:0] S_LOAD = SW'(SETTLE_CYCLES);

   pb_gen_state_t  state;
   logic           target;
   logic [TW-1:0]  tcnt;
   logic [GW-1:0]  gcnt;
   logic [SW-1:0]  scnt;
   logic [15:0]    lfsr_q;
   logic           adv;
   logic [GW-1:0]  gap_load;
   logic           lfsr_unused;

   // A toggle fires on the edge the gap counter would reach zero,
   // so a loaded gap g spaces two toggles exactly g cycles apart.
   assign adv      = (state == BOUNCE) && (gcnt <= GW'(1));
   assign gap_load = {1'b0, lfsr_q[GAP_BITS-1:0]} + GW'(1);
   assign lfsr_unused = ^lfsr_q[15:GAP_BITS];

   lfsr16 #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clk_20mhz(clk_20mhz),
      .rst      (rst),
      .adv      (adv),
      .q        (lfsr_q)
   );

   always_ff @(posedge clk_20mhz or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         target <= 1'b0;
         tcnt   <= '0;
         gcnt   <= '0;
         scnt   <= '0;
         PB     <= 1'b0;
         busy   <= 1'b0;
         held   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (press_req) begin
                  target <= 1'b1;
                  tcnt   <= '0;
                  gcnt   <= '0;
                  state  <= BOUNCE;
               end
            end
            HELD: begin
               busy <= 1'b0;
               if (release_req) begin
                  target <= 1'b0;
                  tcnt   <= '0;
                  gcnt   <= '0;
                  held   <= 1'b0;
                  state  <= BOUNCE;
               end
            end
            BOUNCE: begin
               if (adv) begin
                  PB   <= ~PB;
                  busy <= 1'b1;
                  tcnt <= tcnt + TW'(1);
                  gcnt <= gap_load;
                  if (tcnt + TW'(1) == T_LAST) begin
                     scnt  <= S_LOAD;
                     state <= SETTLE;
                  end
               end else begin
                  gcnt <= gcnt - GW'(1);
               end
            end
            SETTLE: begin
               if (scnt <= SW'(1)) begin
                  scnt  <= '0;
                  done  <= 1'b1;
                  held  <= target;
                  state <= target ? HELD : IDLE;
               end else begin
                  scnt <= scnt - SW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
